// File: rtl/cpu_coherence_controller.sv
// CPU-side coherence controller for a snoopy invalidate cache: sequences each CPU
// access through hit check, victim write-back, fetch or invalidate, then line update.
module cpu_coherence_controller #(
    parameter int ADDRESS_WIDTH = 16,
    parameter bit MESI_MODE     = 1'b1,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpuRead,
    input  logic                     cpuWrite,
    input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
    input  logic                     hit,
    input  logic [1:0]               stateIn,
    input  logic [ADDRESS_WIDTH-1:0] victimAddress,
    input  logic                     busDone,
    input  logic                     sharedIn,
    input  logic                     countersClear,
    output logic                     cpuDone,
    output logic                     stateWrite,
    output logic [1:0]               stateOut,
    output logic                     busRequest,
    output logic [2:0]               busCommand,
    output logic [ADDRESS_WIDTH-1:0] busAddress,
    output logic [COUNTER_WIDTH-1:0] hitCount,
    output logic [COUNTER_WIDTH-1:0] missCount,
    output logic [COUNTER_WIDTH-1:0] writeBackCount
);

    typedef enum logic [2:0] {IDLE, WRITE_BACK, FETCH, INVALIDATE, DONE} fsm_t;

    localparam logic [1:0] ST_INVALID   = 2'd0;
    localparam logic [1:0] ST_SHARED    = 2'd1;
    localparam logic [1:0] ST_EXCLUSIVE = 2'd2;
    localparam logic [1:0] ST_MODIFIED  = 2'd3;

    localparam logic [2:0] CMD_NONE       = 3'd0;
    localparam logic [2:0] CMD_READ       = 3'd1;
    localparam logic [2:0] CMD_READ_EXCL  = 3'd2;
    localparam logic [2:0] CMD_INVALIDATE = 3'd3;
    localparam logic [2:0] CMD_WRITE_BACK = 3'd4;

    localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

    fsm_t                     state;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     is_write_q;
    logic                     hit_path_q;
    logic [1:0]               line_state;
    logic                     line_hit;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (v == COUNT_MAX) ? v : v + 1'b1;
    endfunction

    // Without MESI an Exclusive line is indistinguishable from Shared.
    always_comb begin
        line_state = stateIn;
        if (!MESI_MODE && stateIn == ST_EXCLUSIVE) line_state = ST_SHARED;
    end

    assign line_hit = hit && (line_state != ST_INVALID);

    // NOTE: reset is synchronous, so it is only tested inside the clocked block and
    // every register (including the address latch) gets a defined value from it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            is_write_q     <= 1'b0;
            hit_path_q     <= 1'b0;
            cpuDone        <= 1'b0;
            stateWrite     <= 1'b0;
            stateOut       <= ST_INVALID;
            busRequest     <= 1'b0;
            busCommand     <= CMD_NONE;
            busAddress     <= '0;
            hitCount       <= '0;
            missCount      <= '0;
            writeBackCount <= '0;
        end else begin
            // NOTE: pulse outputs default low with a non-blocking assignment; a later
            // assignment in the same block overrides it, so no pulse can stick high.
            cpuDone    <= 1'b0;
            stateWrite <= 1'b0;

            if (countersClear) begin
                hitCount       <= '0;
                missCount      <= '0;
                writeBackCount <= '0;
            end else begin
                if (state == DONE && hit_path_q)  hitCount  <= sat_inc(hitCount);
                if (state == DONE && !hit_path_q) missCount <= sat_inc(missCount);
                if (state == WRITE_BACK && busDone) writeBackCount <= sat_inc(writeBackCount);
            end

            case (state)
                IDLE: begin
                    if (cpuRead || cpuWrite) begin
                        addr_q     <= cpuAddress;
                        is_write_q <= cpuWrite;
                        hit_path_q <= line_hit;
                        if (line_hit) begin
                            if (!cpuWrite || line_state == ST_MODIFIED) begin
                                cpuDone <= 1'b1;
                                state   <= DONE;
                            end else if (line_state == ST_EXCLUSIVE) begin
                                cpuDone    <= 1'b1;
                                stateWrite <= 1'b1;
                                stateOut   <= ST_MODIFIED;
                                state      <= DONE;
                            end else begin
                                busRequest <= 1'b1;
                                busCommand <= CMD_INVALIDATE;
                                busAddress <= cpuAddress;
                                state      <= INVALIDATE;
                            end
                        end else if (line_state == ST_MODIFIED) begin
                            busRequest <= 1'b1;
                            busCommand <= CMD_WRITE_BACK;
                            busAddress <= victimAddress;
                            state      <= WRITE_BACK;
                        end else begin
                            busRequest <= 1'b1;
                            busCommand <= cpuWrite ? CMD_READ_EXCL : CMD_READ;
                            busAddress <= cpuAddress;
                            state      <= FETCH;
                        end
                    end
                end
                WRITE_BACK: begin
                    // The write-back request drops for a cycle before the fetch is raised.
                    if (busDone) begin
                        busRequest <= 1'b0;
                        busCommand <= CMD_NONE;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (!busRequest) begin
                        busRequest <= 1'b1;
                        busCommand <= is_write_q ? CMD_READ_EXCL : CMD_READ;
                        busAddress <= addr_q;
                    end else if (busDone) begin
                        busRequest <= 1'b0;
                        busCommand <= CMD_NONE;
                        cpuDone    <= 1'b1;
                        stateWrite <= 1'b1;
                        if (is_write_q)                 stateOut <= ST_MODIFIED;
                        else if (sharedIn || !MESI_MODE) stateOut <= ST_SHARED;
                        else                             stateOut <= ST_EXCLUSIVE;
                        state <= DONE;
                    end
                end
                INVALIDATE: begin
                    if (busDone) begin
                        busRequest <= 1'b0;
                        busCommand <= CMD_NONE;
                        cpuDone    <= 1'b1;
                        stateWrite <= 1'b1;
                        stateOut   <= ST_MODIFIED;
                        state      <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_coherence_controller.sv
// Directed bench for cpu_coherence_controller: a MESI instance (a) and an MSI instance (b)
// with a delay-programmable bus responder per instance.
module tb_cpu_coherence_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_read = 1'b0, cpu_write = 1'b0;
    logic        cpu_read_b = 1'b0, cpu_write_b = 1'b0;
    logic [15:0] cpu_address = '0, victim_address = '0;
    logic        hit = 1'b0;
    logic [1:0]  state_in = 2'd0;
    logic        bus_done = 1'b0, bus_done_b = 1'b0;
    logic        shared_in = 1'b0;
    logic        counters_clear = 1'b0;

    logic        cpu_done_a, state_write_a, bus_request_a;
    logic [1:0]  state_out_a;
    logic [2:0]  bus_command_a;
    logic [15:0] bus_address_a;
    logic [7:0]  hit_count_a, miss_count_a, wb_count_a;

    logic        cpu_done_b, state_write_b, bus_request_b;
    logic [1:0]  state_out_b;
    logic [2:0]  bus_command_b;
    logic [15:0] bus_address_b;
    logic [7:0]  hit_count_b, miss_count_b, wb_count_b;

    int tests_run = 0;
    int tests_failed = 0;

    int bus_delay = 1, bus_delay_b = 1;
    int age_a = 0, age_b = 0;
    int req_cycles_a = 0, req_cycles_b = 0;
    bit unstable_a = 1'b0;
    logic [2:0]  log_cmd[$];
    logic [15:0] log_addr[$];
    int          log_len[$];

    cpu_coherence_controller #(.ADDRESS_WIDTH(16), .MESI_MODE(1'b1), .COUNTER_WIDTH(8)) dut_a (
        .clock(clock), .reset(reset), .cpuRead(cpu_read), .cpuWrite(cpu_write),
        .cpuAddress(cpu_address), .hit(hit), .stateIn(state_in), .victimAddress(victim_address),
        .busDone(bus_done), .sharedIn(shared_in), .countersClear(counters_clear),
        .cpuDone(cpu_done_a), .stateWrite(state_write_a), .stateOut(state_out_a),
        .busRequest(bus_request_a), .busCommand(bus_command_a), .busAddress(bus_address_a),
        .hitCount(hit_count_a), .missCount(miss_count_a), .writeBackCount(wb_count_a)
    );

    cpu_coherence_controller #(.ADDRESS_WIDTH(16), .MESI_MODE(1'b0), .COUNTER_WIDTH(8)) dut_b (
        .clock(clock), .reset(reset), .cpuRead(cpu_read_b), .cpuWrite(cpu_write_b),
        .cpuAddress(cpu_address), .hit(hit), .stateIn(state_in), .victimAddress(victim_address),
        .busDone(bus_done_b), .sharedIn(shared_in), .countersClear(counters_clear),
        .cpuDone(cpu_done_b), .stateWrite(state_write_b), .stateOut(state_out_b),
        .busRequest(bus_request_b), .busCommand(bus_command_b), .busAddress(bus_address_b),
        .hitCount(hit_count_b), .missCount(miss_count_b), .writeBackCount(wb_count_b)
    );

    always #5 clock = ~clock;

    // Bus responder: completes each transaction in its bus_delay-th request cycle.
    always @(posedge clock) begin
        #2;
        if (bus_request_a) begin
            age_a++;
            req_cycles_a++;
            if (age_a == 1) begin
                log_cmd.push_back(bus_command_a);
                log_addr.push_back(bus_address_a);
                log_len.push_back(0);
            end else if (bus_command_a !== log_cmd[log_cmd.size()-1] ||
                         bus_address_a !== log_addr[log_addr.size()-1]) begin
                unstable_a = 1'b1;
            end
            log_len[log_len.size()-1] += 1;
            bus_done = (age_a == bus_delay);
        end else begin
            age_a    = 0;
            bus_done = 1'b0;
        end
        if (bus_request_b) begin
            age_b++;
            req_cycles_b++;
            bus_done_b = (age_b == bus_delay_b);
        end else begin
            age_b      = 0;
            bus_done_b = 1'b0;
        end
    end

    // Issues one request on instance a at a negedge and waits for cpuDone.
    task automatic cpu_op_a(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic h, input logic [1:0] st, output int cycles,
                            output logic sw, output logic [1:0] so, output bit timeout);
        cpu_read = rd; cpu_write = wr; cpu_address = addr; hit = h; state_in = st;
        cycles = 0; timeout = 1'b1; sw = 1'b0; so = 2'd0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            cycles++;
            if (cpu_done_a) begin
                sw = state_write_a; so = state_out_a; timeout = 1'b0;
                break;
            end
        end
        cpu_read = 1'b0; cpu_write = 1'b0; hit = 1'b0;
    endtask

    task automatic clear_log();
        log_cmd.delete(); log_addr.delete(); log_len.delete();
        unstable_a = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        tests_run++;
        if ({cpu_done_a, state_write_a, state_out_a, bus_request_a, bus_command_a, bus_address_a} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got done=%b sw=%b so=%0d req=%b cmd=%0d addr=%h, expected all 0",
                     cpu_done_a, state_write_a, state_out_a, bus_request_a, bus_command_a, bus_address_a);
        end
        tests_run++;
        if ({hit_count_a, miss_count_a, wb_count_a} !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0", hit_count_a, miss_count_a, wb_count_a);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_read_hit();
        int cyc; logic sw; logic [1:0] so; bit to; int req0;
        req0 = req_cycles_a;
        cpu_op_a(1'b1, 1'b0, 16'h0040, 1'b1, 2'd1, cyc, sw, so, to);
        tests_run++;
        if (to || cyc != 1 || sw !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_hit: got timeout=%0d cycles=%0d sw=%b, expected 0/1/0", to, cyc, sw);
        end
        @(negedge clock);
        tests_run++;
        if (req_cycles_a != req0 || hit_count_a !== 8'd1 || miss_count_a !== 8'd0) begin
            tests_failed++;
            $display("FAIL read_hit_stats: got req_cycles=%0d hit=%0d miss=%0d, expected 0/1/0",
                     req_cycles_a - req0, hit_count_a, miss_count_a);
        end
    endtask

    task automatic test_silent_upgrade();
        int cyc; logic sw; logic [1:0] so; bit to; int req0;
        req0 = req_cycles_a;
        cpu_op_a(1'b0, 1'b1, 16'h0080, 1'b1, 2'd2, cyc, sw, so, to);
        tests_run++;
        if (to || cyc != 1 || sw !== 1'b1 || so !== 2'd3 || req_cycles_a != req0) begin
            tests_failed++;
            $display("FAIL silent_upgrade: got timeout=%0d cycles=%0d sw=%b so=%0d req_cycles=%0d, expected 0/1/1/3/0",
                     to, cyc, sw, so, req_cycles_a - req0);
        end
        @(negedge clock);
        // Read and write together act as a write: silent upgrade again.
        cpu_op_a(1'b1, 1'b1, 16'h0084, 1'b1, 2'd2, cyc, sw, so, to);
        tests_run++;
        if (to || cyc != 1 || sw !== 1'b1 || so !== 2'd3) begin
            tests_failed++;
            $display("FAIL read_write_as_write: got timeout=%0d cycles=%0d sw=%b so=%0d, expected 0/1/1/3",
                     to, cyc, sw, so);
        end
        @(negedge clock);
        tests_run++;
        if (hit_count_a !== 8'd3) begin
            tests_failed++;
            $display("FAIL upgrade_hit_count: got %0d, expected 3", hit_count_a);
        end
    endtask

    task automatic test_msi_upgrade();
        logic [2:0] first_cmd; bit seen; bit done_seen; logic [1:0] so; logic sw;
        bus_delay_b = 2; seen = 1'b0; done_seen = 1'b0; first_cmd = 3'd0; so = 2'd0; sw = 1'b0;
        cpu_write_b = 1'b1; cpu_address = 16'h00C0; hit = 1'b1; state_in = 2'd2;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(negedge clock);
            if (bus_request_b && !seen) begin first_cmd = bus_command_b; seen = 1'b1; end
            if (cpu_done_b) begin done_seen = 1'b1; so = state_out_b; sw = state_write_b; end
        end
        cpu_write_b = 1'b0; hit = 1'b0;
        tests_run++;
        if (!done_seen || !seen || first_cmd !== 3'd3 || so !== 2'd3 || sw !== 1'b1) begin
            tests_failed++;
            $display("FAIL msi_write_exclusive: got done=%0d cmd=%0d so=%0d sw=%b, expected 1/3/3/1",
                     done_seen, first_cmd, so, sw);
        end
        @(negedge clock);
        tests_run++;
        if (hit_count_b !== 8'd1 || miss_count_b !== 8'd0) begin
            tests_failed++;
            $display("FAIL msi_stats: got hit=%0d miss=%0d, expected 1/0", hit_count_b, miss_count_b);
        end
    endtask

    task automatic test_writeback_miss();
        int cyc; logic sw; logic [1:0] so; bit to;
        clear_log();
        bus_delay = 3; shared_in = 1'b0; victim_address = 16'h1200;
        cpu_op_a(1'b1, 1'b0, 16'h3400, 1'b0, 2'd3, cyc, sw, so, to);
        tests_run++;
        if (to || sw !== 1'b1 || so !== 2'd2) begin
            tests_failed++;
            $display("FAIL wb_miss_state: got timeout=%0d sw=%b so=%0d, expected 0/1/2", to, sw, so);
        end
        tests_run++;
        if (log_cmd.size() != 2) begin
            tests_failed++;
            $display("FAIL wb_miss_txn_count: got %0d transactions, expected 2", log_cmd.size());
        end else if (log_cmd[0] !== 3'd4 || log_addr[0] !== 16'h1200 || log_len[0] != 3 ||
                     log_cmd[1] !== 3'd1 || log_addr[1] !== 16'h3400 || log_len[1] != 3 || unstable_a) begin
            tests_failed++;
            $display("FAIL wb_miss_txns: got %0d@%h x%0d, %0d@%h x%0d unstable=%0d, expected 4@1200 x3, 1@3400 x3 unstable=0",
                     log_cmd[0], log_addr[0], log_len[0], log_cmd[1], log_addr[1], log_len[1], unstable_a);
        end
        @(negedge clock);
        tests_run++;
        if (wb_count_a !== 8'd1 || miss_count_a !== 8'd1 || hit_count_a !== 8'd3) begin
            tests_failed++;
            $display("FAIL wb_miss_stats: got wb=%0d miss=%0d hit=%0d, expected 1/1/3", wb_count_a, miss_count_a, hit_count_a);
        end
    endtask

    task automatic test_shared_fetch();
        int cyc; logic sw; logic [1:0] so; bit to;
        clear_log();
        bus_delay = 1; shared_in = 1'b1;
        cpu_op_a(1'b1, 1'b0, 16'h5600, 1'b0, 2'd0, cyc, sw, so, to);
        shared_in = 1'b0;
        tests_run++;
        if (to || so !== 2'd1 || sw !== 1'b1 || log_len.size() != 1 || req_total_one()) begin
            tests_failed++;
            $display("FAIL shared_fetch: got timeout=%0d so=%0d sw=%b txns=%0d, expected 0/1/1 one txn of 1 cycle",
                     to, so, sw, log_len.size());
        end
        @(negedge clock);
        // Write miss with a clean victim fetches exclusively and lands Modified.
        clear_log();
        cpu_op_a(1'b0, 1'b1, 16'h5700, 1'b0, 2'd1, cyc, sw, so, to);
        tests_run++;
        if (to || so !== 2'd3 || log_cmd.size() != 1 || log_cmd[0] !== 3'd2 || log_addr[0] !== 16'h5700) begin
            tests_failed++;
            $display("FAIL write_miss: got timeout=%0d so=%0d txns=%0d, expected 0/3 one READ_EXCLUSIVE at 5700",
                     to, so, log_cmd.size());
        end
        @(negedge clock);
        // Write hit Shared needs a bus invalidate.
        clear_log();
        bus_delay = 2;
        cpu_op_a(1'b0, 1'b1, 16'h5800, 1'b1, 2'd1, cyc, sw, so, to);
        tests_run++;
        if (to || so !== 2'd3 || sw !== 1'b1 || log_cmd.size() != 1 || log_cmd[0] !== 3'd3 || log_addr[0] !== 16'h5800) begin
            tests_failed++;
            $display("FAIL write_hit_shared: got timeout=%0d so=%0d sw=%b txns=%0d, expected 0/3/1 one INVALIDATE at 5800",
                     to, so, sw, log_cmd.size());
        end
        @(negedge clock);
        tests_run++;
        if (hit_count_a !== 8'd4 || miss_count_a !== 8'd3 || wb_count_a !== 8'd1) begin
            tests_failed++;
            $display("FAIL mixed_stats: got hit=%0d miss=%0d wb=%0d, expected 4/3/1", hit_count_a, miss_count_a, wb_count_a);
        end
    endtask

    function automatic bit req_total_one();
        return (log_len.size() == 0) ? 1'b1 : (log_len[0] != 1);
    endfunction

    task automatic test_reset_mid_fetch();
        int cyc; logic sw; logic [1:0] so; bit to; bit seen;
        bus_delay = 20; seen = 1'b0;
        cpu_read = 1'b1; cpu_address = 16'h7000; hit = 1'b0; state_in = 2'd0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            seen = bus_request_a;
        end
        reset = 1'b1; cpu_read = 1'b0;
        @(negedge clock);
        tests_run++;
        if (!seen || bus_request_a !== 1'b0 || cpu_done_a !== 1'b0 || state_write_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_fetch: got fetch_seen=%0d req=%b done=%b sw=%b, expected 1/0/0/0",
                     seen, bus_request_a, cpu_done_a, state_write_a);
        end
        reset = 1'b0;
        bus_delay = 1;
        @(negedge clock);
        cpu_op_a(1'b1, 1'b0, 16'h7100, 1'b1, 2'd1, cyc, sw, so, to);
        tests_run++;
        if (to || cyc != 1) begin
            tests_failed++;
            $display("FAIL after_reset_hit: got timeout=%0d cycles=%0d, expected 0/1", to, cyc);
        end
        @(negedge clock);
        tests_run++;
        if (hit_count_a !== 8'd1 || miss_count_a !== 8'd0 || wb_count_a !== 8'd0) begin
            tests_failed++;
            $display("FAIL after_reset_stats: got hit=%0d miss=%0d wb=%0d, expected 1/0/0", hit_count_a, miss_count_a, wb_count_a);
        end
    endtask

    task automatic test_saturation();
        int cyc; logic sw; logic [1:0] so; bit to; int timeouts; bit done_seen;
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            cpu_op_a(1'b1, 1'b0, 16'h0100, 1'b1, 2'd1, cyc, sw, so, to);
            if (to) timeouts++;
            @(negedge clock);
        end
        tests_run++;
        if (timeouts != 0 || hit_count_a !== 8'd255) begin
            tests_failed++;
            $display("FAIL hit_saturation: got timeouts=%0d hit=%0d, expected 0/255", timeouts, hit_count_a);
        end
        // Clear lands on the same edge as the hit increment.
        cpu_read = 1'b1; cpu_address = 16'h0104; hit = 1'b1; state_in = 2'd1;
        done_seen = 1'b0;
        for (int i = 0; i < 10 && !done_seen; i++) begin
            @(negedge clock);
            if (cpu_done_a) begin done_seen = 1'b1; counters_clear = 1'b1; end
        end
        cpu_read = 1'b0; hit = 1'b0;
        @(negedge clock);
        counters_clear = 1'b0;
        tests_run++;
        if (!done_seen || hit_count_a !== 8'd0 || miss_count_a !== 8'd0) begin
            tests_failed++;
            $display("FAIL clear_priority: got done=%0d hit=%0d miss=%0d, expected 1/0/0", done_seen, hit_count_a, miss_count_a);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_silent_upgrade();
        test_msi_upgrade();
        test_writeback_miss();
        test_shared_fetch();
        test_reset_mid_fetch();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_coherence_controller.md
Name: cpu_coherence_controller

Overview:
- CPU-side coherence controller for the snoopy invalidate-protocol cache, parametrised successor of the CPU/protocol handshake.
- Sequences each CPU read/write through hit check, optional dirty-victim write-back, bus fetch or invalidate, then line-state update.
- Supports MSI and MESI modes and carries saturating hit/miss/write-back statistics.
- Sits between the cache CPU port and the bus arbiter front end.

Parameters:
ADDRESS_WIDTH, 16, width of cpuAddress, victimAddress, busAddress
MESI_MODE, 1, 1 = MESI (Exclusive state produced and used); 0 = MSI
COUNTER_WIDTH, 8, width of each statistics counter

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
cpuRead  input  1  CPU read request, held until cpuDone
cpuWrite  input  1  CPU write request, held until cpuDone
cpuAddress  input  ADDRESS_WIDTH  request address
hit  input  1  tag match for cpuAddress
stateIn  input  2  state of hit line, or of victim line on miss
victimAddress  input  ADDRESS_WIDTH  address of victim line
busDone  input  1  current bus transaction complete
sharedIn  input  1  another cache holds the line; valid with busDone
countersClear  input  1  synchronous clear of statistics
cpuDone  output  1  one-cycle completion pulse
stateWrite  output  1  write stateOut into the line, one cycle
stateOut  output  2  new line state
busRequest  output  1  bus transaction request
busCommand  output  3  0 NONE, 1 READ, 2 READ_EXCLUSIVE, 3 INVALIDATE, 4 WRITE_BACK
busAddress  output  ADDRESS_WIDTH  bus transaction address
hitCount, missCount, writeBackCount  output  COUNTER_WIDTH each  statistics

Behaviour:
- State encoding: INVALID 0, SHARED 1, EXCLUSIVE 2, MODIFIED 3. hit with stateIn INVALID counts as miss.
- FSM states: IDLE, WRITE_BACK, FETCH, INVALIDATE, DONE. All outputs registered.
- Reset values: FSM IDLE, all outputs 0, counters 0. Reset mid-transaction returns to IDLE next cycle with busRequest 0 and no stateWrite/cpuDone.
- Simultaneous cpuRead and cpuWrite are treated as a write.
- With MESI_MODE=0, stateIn EXCLUSIVE is treated as SHARED.
- IDLE, on request; latch address and operation:
  - read hit -> DONE, no state change
  - write hit MODIFIED -> DONE, no state change
  - write hit EXCLUSIVE -> DONE, new state MODIFIED (silent upgrade, no bus traffic)
  - write hit SHARED -> INVALIDATE
  - miss with stateIn MODIFIED -> WRITE_BACK
  - other miss -> FETCH
- WRITE_BACK: busRequest=1, busCommand=4, busAddress=victimAddress until busDone; then FETCH; writeBackCount increments.
- FETCH: busRequest=1, command READ (read) or READ_EXCLUSIVE (write), busAddress=cpuAddress. On busDone:
  - write: new state MODIFIED
  - read: sharedIn=1 or MESI_MODE=0 gives SHARED, otherwise EXCLUSIVE
  - then -> DONE
- INVALIDATE: busRequest=1, command 3 until busDone; new state MODIFIED; -> DONE.
- busCommand/busAddress stable while busRequest=1. busDone is honoured in the first request cycle. Request drops the cycle after busDone.
- DONE, one cycle: cpuDone=1; stateWrite=1 only when a new state was set; stateOut = new state; -> IDLE.
- Latency: a plain hit gives cpuDone 1 cycle after the request is sampled; a silent upgrade also takes 1 cycle.
- Counters: hitCount (hit path) or missCount (miss path) increments in DONE.
  - All counters saturate at all-ones.
  - countersClear has priority over increment in the same cycle.

Test Plan:
- Read hit, stateIn=SHARED -> cpuDone at cycle 1, stateWrite=0, busRequest never asserted, hitCount=1.
- Write hit EXCLUSIVE, MESI_MODE=1 -> cycle 1 cpuDone=1, stateWrite=1, stateOut=3. Same stimulus with MESI_MODE=0 -> INVALIDATE command 3, stateOut=3 after busDone.
- Read miss, victim MODIFIED at 0x1200, cpuAddress 0x3400, busDone after 3 cycles each, sharedIn=0:
  - command 4 at 0x1200, then command 1 at 0x3400
  - stateOut=2, writeBackCount=1, missCount=1
- Read miss, sharedIn=1 with busDone in the first request cycle -> stateOut=1, busRequest high exactly 1 cycle.
- Reset asserted during FETCH -> next cycle IDLE, busRequest=0, no cpuDone; a subsequent request proceeds normally.
- 300 read hits with COUNTER_WIDTH=8 -> hitCount=255. countersClear together with a hit -> 0.
